rr_reg_write_arbiter: RTL and testbench

Round-robin arbiter that shares one enable-gated N-bit holding register between NREQ requesters.
- Each requester presents write data plus a request.
- The arbiter selects one winner, loads its data into the shared register and returns a one-cycle grant.
- An optional hold interval spaces consecutive writes. Sits in front of shared config/data registers in the datapath.

---
 rtl/rr_reg_write_arbiter_if.sv | 26 ++
 rtl/rr_reg_write_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_reg_write_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_reg_write_arbiter_if.sv
// Requester-side bundle for the shared register write arbiter.
// Carries requests, write data, flush and the grant/register view.
interface rr_reg_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  flush;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        gnt_id;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic                  busy;

  modport master (
    output req, wdata, flush,
    input  gnt, gnt_id, q, q_valid, busy
  );

  modport slave (
    input  req, wdata, flush,
    output gnt, gnt_id, q, q_valid, busy
  );
endinterface

// File: rtl/rr_reg_write_arbiter.sv
// Round-robin arbiter feeding one shared holding register.
// Optional macro RR_ARB_REQ0_PRIORITY_EN: requester 0 always wins.
module rr_reg_write_arbiter #(
  parameter int WIDTH       = 8,
  parameter int NREQ        = 4,
  parameter int HOLD_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  rr_reg_write_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] HOLD_LD =
    (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qv_q, qv_d;

  logic             found;
  logic [NREQ-1:0]  rot;
  logic [IDW:0]     off, sum;
  logic [IDW-1:0]   win, ptr_nxt;
  logic [WIDTH-1:0] wd [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_wd
    assign wd[g] = bus.wdata[g*WIDTH +: WIDTH];
  end

  // Rotate requests so ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    rot   = NREQ'({bus.req, bus.req} >> ptr_q);
    found = 1'b0;
    off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = k[IDW:0];
      end
    end
    sum = {1'b0, ptr_q} + off;
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end
    win     = sum[IDW-1:0];
    ptr_nxt = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
`ifdef RR_ARB_REQ0_PRIORITY_EN
    if (bus.req[0]) begin
      win     = '0;
      ptr_nxt = ptr_q;
    end
`endif
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  // Next state: arbitrate only in IDLE, then GRANT and optional HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    q_d     = q_q;
    qv_d    = qv_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.flush && found) begin
          state_d = GRANT;
          q_d     = wd[win];
          qv_d    = 1'b1;
          id_d    = win;
          ptr_d   = ptr_nxt;
        end
      end
      GRANT: begin
        if (HOLD_CYCLES > 0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      q_d  = '0;
      qv_d = 1'b0;
    end
  end

  // Outputs: grant pulse derived from the registered GRANT state.
  always_comb begin
    bus.gnt  = '0;
    bus.busy = (state_q != IDLE);
    if (state_q == GRANT) begin
      bus.gnt = NREQ'(1) << id_q;
    end
  end

  assign bus.gnt_id  = id_q;
  assign bus.q       = q_q;
  assign bus.q_valid = qv_q;
endmodule

// File: tb/tb_rr_reg_write_arbiter.sv
// Bench for rr_reg_write_arbiter: HOLD_CYCLES=0 and =3 instances
// share stimulus; a queue-free arithmetic model predicts each cycle.
module tb_rr_reg_write_arbiter;
  logic        clk;
  logic        rst;
  logic [3:0]  rq;
  logic [31:0] wd;
  logic        fl;

  int checks = 0;
  int errors = 0;

  rr_reg_write_arbiter_if #(.WIDTH(8), .NREQ(4)) if0 ();
  rr_reg_write_arbiter_if #(.WIDTH(8), .NREQ(4)) if3 ();

  assign if0.req   = rq;
  assign if0.wdata = wd;
  assign if0.flush = fl;
  assign if3.req   = rq;
  assign if3.wdata = wd;
  assign if3.flush = fl;

  rr_reg_write_arbiter #(.WIDTH(8), .NREQ(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst), .bus(if0)
  );
  rr_reg_write_arbiter #(.WIDTH(8), .NREQ(4), .HOLD_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst), .bus(if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: ml = cycles left outside IDLE, mp = pointer
  int ml [2];
  int mp [2];
  int mq [2];
  int mv [2];
  int mid [2];
  int mg [2];

  function automatic int byte_of(logic [31:0] w, int i);
    return int'((w >> (8 * i)) & 32'hFF);
  endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic mstep(int d);
    int hc;
    int w;
    hc = (d == 1) ? 3 : 0;
    if (rst) begin
      ml[d] = 0; mp[d] = 0; mq[d] = 0;
      mv[d] = 0; mid[d] = 0; mg[d] = 0;
    end else if (ml[d] == 0) begin
      mg[d] = 0;
      if (fl) begin
        mq[d] = 0; mv[d] = 0;
      end else begin
        w = -1;
`ifdef RR_ARB_REQ0_PRIORITY_EN
        if (rq[0]) w = 0;
`endif
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && rq[(mp[d] + k) % 4]) w = (mp[d] + k) % 4;
        end
        if (w >= 0) begin
          mq[d] = byte_of(wd, w);
          mv[d] = 1;
          mid[d] = w;
          mg[d] = 1 << w;
          ml[d] = 1 + hc;
`ifdef RR_ARB_REQ0_PRIORITY_EN
          if (w != 0)
`endif
          mp[d] = (w + 1) % 4;
        end
      end
    end else begin
      ml[d]--;
      mg[d] = 0;
      if (fl) begin
        mq[d] = 0; mv[d] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk("m0_gnt", int'(if0.gnt), mg[0]);
    chk("m0_id", int'(if0.gnt_id), mid[0]);
    chk("m0_q", int'(if0.q), mq[0]);
    chk("m0_qv", int'(if0.q_valid), mv[0]);
    chk("m0_busy", int'(if0.busy), int'(ml[0] > 0));
    chk("m3_gnt", int'(if3.gnt), mg[1]);
    chk("m3_id", int'(if3.gnt_id), mid[1]);
    chk("m3_q", int'(if3.q), mq[1]);
    chk("m3_qv", int'(if3.q_valid), mv[1]);
    chk("m3_busy", int'(if3.busy), int'(ml[1] > 0));
  endtask

  typedef struct {
    logic [3:0] req;
    logic       f;
    logic [3:0] g;
    int         id;
    logic [7:0] q;
    logic       v;
    logic       b;
  } vec_t;

  vec_t tv [10];

  initial begin
    int n;
    int seen;
    logic [3:0] lastg;

    tv[0] = '{4'b0100, 1'b0, 4'b0100, 2, 8'hA5, 1'b1, 1'b1};
    tv[1] = '{4'b0000, 1'b0, 4'b0000, 2, 8'hA5, 1'b1, 1'b0};
    tv[2] = '{4'b1011, 1'b0, 4'b1000, 3, 8'h44, 1'b1, 1'b1};
    tv[3] = '{4'b0011, 1'b0, 4'b0000, 3, 8'h44, 1'b1, 1'b0};
    tv[4] = '{4'b0011, 1'b0, 4'b0001, 0, 8'h11, 1'b1, 1'b1};
    tv[5] = '{4'b0010, 1'b0, 4'b0000, 0, 8'h11, 1'b1, 1'b0};
    tv[6] = '{4'b0010, 1'b1, 4'b0000, 0, 8'h00, 1'b0, 1'b0};
    tv[7] = '{4'b0010, 1'b0, 4'b0010, 1, 8'h22, 1'b1, 1'b1};
    tv[8] = '{4'b0000, 1'b1, 4'b0000, 1, 8'h00, 1'b0, 1'b0};
    tv[9] = '{4'b0000, 1'b0, 4'b0000, 1, 8'h00, 1'b0, 1'b0};

    for (int d = 0; d < 2; d++) begin
      ml[d] = 0; mp[d] = 0; mq[d] = 0;
      mv[d] = 0; mid[d] = 0; mg[d] = 0;
    end

    // reset with all requests high, then idle
    rst = 1'b1; rq = 4'hF; fl = 1'b0; wd = 32'h44A52211;
    cyc();
    cyc();
    chk("rst_gnt", int'(if0.gnt), 0);
    chk("rst_q", int'(if0.q), 0);
    chk("rst_qv", int'(if0.q_valid), 0);
    chk("rst_busy", int'(if3.busy), 0);
    rst = 1'b0; rq = 4'h0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_gnt", int'(if0.gnt), 0);
      chk("idle_q", int'(if0.q), 0);
    end

    // table vectors against the HOLD_CYCLES=0 instance
    for (int i = 0; i < 10; i++) begin
      rq = tv[i].req; fl = tv[i].f;
      cyc();
      chk($sformatf("tv%0d_gnt", i), int'(if0.gnt), int'(tv[i].g));
      chk($sformatf("tv%0d_id", i), int'(if0.gnt_id), tv[i].id);
      chk($sformatf("tv%0d_q", i), int'(if0.q), int'(tv[i].q));
      chk($sformatf("tv%0d_qv", i), int'(if0.q_valid), int'(tv[i].v));
      chk($sformatf("tv%0d_busy", i), int'(if0.busy), int'(tv[i].b));
    end
    fl = 1'b0;

    // fairness: all request, each drops one cycle after own grant
    rst = 1'b1; rq = 4'h0; wd = 32'h9C3E7B51;
    cyc();
    rst = 1'b0; lastg = 4'h0; n = 0;
    for (int i = 0; i < 20; i++) begin
      rq = 4'hF & ~lastg;
      cyc();
      if (if0.gnt != 4'h0) begin
        chk("rr_order", int'(if0.gnt_id), n % 4);
        chk("rr_q", int'(if0.q), byte_of(wd, n % 4));
        n++;
      end
      lastg = if0.gnt;
    end
    chk("rr_count", n, 10);

    // hold spacing and pointer wrap on HOLD_CYCLES=3
    rst = 1'b1; rq = 4'h0;
    cyc();
    rst = 1'b0; rq = 4'b1000;
    cyc();
    chk("h_gnt3", int'(if3.gnt), 8);
    chk("h_busy1", int'(if3.busy), 1);
    rq = 4'b0001;
    for (int k = 2; k <= 6; k++) begin
      cyc();
      chk($sformatf("h_busy%0d", k), int'(if3.busy), int'(k <= 4 || k == 6));
      chk($sformatf("h_gnt_c%0d", k), int'(if3.gnt), (k == 6) ? 1 : 0);
    end
    rq = 4'b0011; seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      cyc();
      if (if3.gnt != 4'h0) seen = 1;
    end
    chk("h_wait", seen, 1);
    chk("h_wrap_id", int'(if3.gnt_id), 1);

    // reset asserted during HOLD
    rq = 4'h0;
    for (int i = 0; i < 5; i++) cyc();
    rq = 4'b0100;
    cyc();
    chk("rh_gnt", int'(if3.gnt), 4);
    rq = 4'h0;
    cyc();
    chk("rh_hold", int'(if3.busy), 1);
    rst = 1'b1;
    cyc();
    chk("rh_busy", int'(if3.busy), 0);
    chk("rh_qv", int'(if3.q_valid), 0);
    chk("rh_id", int'(if3.gnt_id), 0);
    rst = 1'b0; rq = 4'b1010;
    cyc();
    chk("rh_ptr0", int'(if3.gnt), 2);
    rq = 4'h0;
    for (int i = 0; i < 5; i++) cyc();

    // req0 and req1 held continuously
    rst = 1'b1;
    cyc();
    rst = 1'b0; rq = 4'b0011; n = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (if0.gnt != 4'h0) begin
`ifdef RR_ARB_REQ0_PRIORITY_EN
        chk("p_id", int'(if0.gnt_id), 0);
`else
        chk("p_id", int'(if0.gnt_id), n % 2);
`endif
        n++;
      end
    end
    chk("p_count", n, 6);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(63) == 0);
      fl  = ($urandom_range(15) == 0);
      rq  = 4'($urandom);
      wd  = $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
